// File: rtl/vm_alu_seq_if.sv
// ----------------------------------------------------------------------------
// vm_alu_seq_if
// Handshake bundle between the vending-machine front end, the registered ALU
// and the controller FSM that consumes its result.
//
// Request side (producer -> ALU):
//   in_valid   request present
//   in_ready   ALU can take the request this cycle
//   a, b       unsigned operands, WIDTH bits
//   op         3-bit operation select
// Response side (ALU -> consumer):
//   out_valid  result registers hold an undelivered result
//   out_ready  consumer takes the result this cycle
//   result     registered result, WIDTH bits
//   equal, greater, carry, zero, err   registered flags
//   acc_value  current credit accumulator contents
//
// Modports:
//   slave  : the ALU itself
//   master : the surrounding producer/consumer (front end + controller)
// ----------------------------------------------------------------------------
interface vm_alu_seq_if #(
  parameter int WIDTH = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             equal;
  logic             greater;
  logic             carry;
  logic             zero;
  logic             err;
  logic [WIDTH-1:0] acc_value;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, equal, greater, carry, zero, err,
           acc_value
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, equal, greater, carry, zero, err,
           acc_value
  );

endinterface

// File: rtl/vm_alu_seq.sv
// ----------------------------------------------------------------------------
// vm_alu_seq
// Registered ALU for the vending-machine datapath. Replaces the old 5-bit
// combinational add/sub/compare unit with:
//   - valid/ready handshake on request and response side
//   - a single output register stage (fixed 1-cycle latency)
//   - saturating subtract for change calculation
//   - an internal credit accumulator with saturating add and guarded debit
//
// Parameters:
//   WIDTH    operand / result / accumulator width
//   ACC_MAX  accumulator saturation ceiling, 1 .. 2**WIDTH-1
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    vm_alu_seq_if slave modport (request, response, flags, acc_value)
//
// Op encodings:
//   000 ADD      001 SUB      010 CMP      011 SSUB
//   100 ACC_ADD  101 ACC_SUB  110 ACC_CLR  111 reserved (err=1)
// ----------------------------------------------------------------------------
module vm_alu_seq #(
  parameter int WIDTH   = 5,
  parameter int ACC_MAX = 2**WIDTH - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  vm_alu_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_CMP     = 3'b010,
    OP_SSUB    = 3'b011,
    OP_ACC_ADD = 3'b100,
    OP_ACC_SUB = 3'b101,
    OP_ACC_CLR = 3'b110,
    OP_RSVD    = 3'b111
  } op_e;

  localparam logic [WIDTH:0] AccMaxX = (WIDTH+1)'(ACC_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             equal_q,   equal_d;
  logic             greater_q, greater_d;
  logic             carry_q,   carry_d;
  logic             zero_q,    zero_d;
  logic             err_q,     err_d;
  logic [WIDTH-1:0] acc_q,     acc_d;

  logic accept;
  op_e  op_sel;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The output register is free when empty or being drained this cycle, which
  // lets a new request overlap the delivery of the previous one.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign op_sel       = op_e'(bus.op);

  // --------------------------------------------------------------------------
  // Arithmetic, all unsigned at WIDTH+1 bits. The extra top bit of a
  // difference is the borrow, since both operands are below 2**WIDTH.
  // --------------------------------------------------------------------------
  logic [WIDTH:0] a_x, b_x, acc_x;
  logic [WIDTH:0] sum_ab, diff_ab, acc_sum, acc_diff;
  logic           borrow_ab, acc_short, acc_over;

  assign a_x   = {1'b0, bus.a};
  assign b_x   = {1'b0, bus.b};
  assign acc_x = {1'b0, acc_q};

  assign sum_ab    = a_x + b_x;
  assign diff_ab   = a_x - b_x;
  assign acc_sum   = acc_x + a_x;
  assign acc_diff  = acc_x - a_x;
  assign borrow_ab = diff_ab[WIDTH];
  assign acc_short = acc_diff[WIDTH];       // acc < a: not enough credit
  assign acc_over  = acc_sum > AccMaxX;

  // --------------------------------------------------------------------------
  // Next-state: the value the output registers take if a request is accepted
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    result_d  = '0;
    carry_d   = 1'b0;
    err_d     = 1'b0;
    acc_d     = acc_q;
    equal_d   = (bus.a == bus.b);
    greater_d = (bus.a >  bus.b);

    case (op_sel)
      OP_ADD: begin
        result_d = sum_ab[WIDTH-1:0];
        carry_d  = sum_ab[WIDTH];
      end
      OP_SUB: begin
        result_d = diff_ab[WIDTH-1:0];
        carry_d  = borrow_ab;
      end
      OP_CMP: begin
        result_d = '0;
      end
      OP_SSUB: begin
        // Change calculation: never go below zero, flag the shortfall.
        result_d = borrow_ab ? '0 : diff_ab[WIDTH-1:0];
        carry_d  = borrow_ab;
      end
      OP_ACC_ADD: begin
        acc_d    = acc_over ? AccMaxX[WIDTH-1:0] : acc_sum[WIDTH-1:0];
        result_d = acc_d;
        carry_d  = acc_over;
      end
      OP_ACC_SUB: begin
        // Guarded debit: an insufficient balance leaves credit untouched.
        acc_d    = acc_short ? acc_q : acc_diff[WIDTH-1:0];
        result_d = acc_d;
        carry_d  = acc_short;
      end
      OP_ACC_CLR: begin
        result_d = acc_q;                   // refund amount
        acc_d    = '0;
      end
      OP_RSVD: begin
        err_d    = 1'b1;
      end
    endcase

    // Accumulator ops compare the pre-op credit against the operand.
    if (op_sel inside {OP_ACC_ADD, OP_ACC_SUB, OP_ACC_CLR}) begin
      equal_d   = (acc_q == bus.a);
      greater_d = (acc_q >  bus.a);
    end

    zero_d = (result_d == '0);
  end

  // --------------------------------------------------------------------------
  // Output register stage and accumulator
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the result registers are reset as well as out_valid because
      // they drive visible outputs the controller may sample at any time.
      out_valid_q <= 1'b0;
      result_q    <= '0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end else if (bus.out_ready) begin
      // Delivered with nothing behind it: result registers keep stale data.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.equal     = equal_q;
  assign bus.greater   = greater_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
  assign bus.acc_value = acc_q;

endmodule
